// File: rtl/apb_delayer_scaled.sv
// rtl/apb_delayer_scaled.sv - APB latency scaler: forwards one transfer, stretches the upstream response.
module apb_delayer_scaled #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int RATIO_NUM   = 2,
    parameter int RATIO_SHIFT = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_bypass,
    input  logic [ADDR_W-1:0]   in_paddr,
    input  logic                in_psel,
    input  logic                in_penable,
    input  logic [2:0]          in_pprot,
    input  logic                in_pwrite,
    input  logic [DATA_W-1:0]   in_pwdata,
    input  logic [DATA_W/8-1:0] in_pstrb,
    output logic                in_pready,
    output logic [DATA_W-1:0]   in_prdata,
    output logic                in_pslverr,
    output logic [ADDR_W-1:0]   out_paddr,
    output logic                out_psel,
    output logic                out_penable,
    output logic [2:0]          out_pprot,
    output logic                out_pwrite,
    output logic [DATA_W-1:0]   out_pwdata,
    output logic [DATA_W/8-1:0] out_pstrb,
    input  logic                out_pready,
    input  logic [DATA_W-1:0]   out_prdata,
    input  logic                out_pslverr,
    output logic                stat_abort
);

    localparam int              PROD_W  = CNT_W + 8;
    localparam logic [7:0]      RATIO   = 8'(RATIO_NUM);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, FWD, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                bypass_q, bypass_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pslverr_q, pslverr_d;
    logic                abort_q, abort_d;

    logic [CNT_W-1:0]    k_inc;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   shifted;
    logic [CNT_W-1:0]    scaled;
    logic [CNT_W-1:0]    target;
    logic [CNT_W-1:0]    rem_calc;

    // Saturating latency arithmetic; target never falls below the measured latency.
    always_comb begin
        k_inc    = (k_q == CNT_MAX) ? k_q : k_q + CNT_W'(1);
        prod     = PROD_W'(k_inc) * PROD_W'(RATIO);
        shifted  = prod >> RATIO_SHIFT;
        scaled   = (|shifted[PROD_W-1:CNT_W]) ? CNT_MAX : shifted[CNT_W-1:0];
        target   = (scaled > k_inc) ? scaled : k_inc;
        rem_calc = target - k_inc;
    end

    assign out_paddr   = in_paddr;
    assign out_pprot   = in_pprot;
    assign out_pwrite  = in_pwrite;
    assign out_pwdata  = in_pwdata;
    assign out_pstrb   = in_pstrb;
    assign out_psel    = in_psel & (bypass_q | (state_q == IDLE) | (state_q == FWD));
    assign out_penable = in_penable & (bypass_q | (state_q == FWD));
    assign in_pready   = bypass_q ? out_pready  : (state_q == RESP);
    assign in_prdata   = bypass_q ? out_prdata  : prdata_q;
    assign in_pslverr  = bypass_q ? out_pslverr : pslverr_q;
    assign stat_abort  = abort_q;

    always_comb begin
        state_d   = state_q;
        bypass_d  = bypass_q;
        k_d       = k_q;
        rem_d     = rem_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        abort_d   = abort_q;
        case (state_q)
            IDLE: begin
                // While bypassing, the FSM parks in IDLE until the slave completes.
                if (bypass_q) begin
                    if (in_psel && in_penable && out_pready) begin
                        bypass_d = 1'b0;
                    end
                end else if (in_psel) begin
                    bypass_d = cfg_bypass;
                    if (!cfg_bypass) begin
                        state_d = FWD;
                        k_d     = '0;
                    end
                end
            end
            FWD: begin
                k_d = k_inc;
                if (!in_psel) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (out_penable && out_pready) begin
                    prdata_d  = out_prdata;
                    pslverr_d = out_pslverr;
                    rem_d     = rem_calc;
                    state_d   = (rem_calc == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                rem_d = rem_q - CNT_W'(1);
                if (!in_psel) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (rem_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            bypass_q  <= 1'b0;
            k_q       <= '0;
            rem_q     <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bypass_q  <= bypass_d;
            k_q       <= k_d;
            rem_q     <= rem_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            abort_q   <= abort_d;
        end
    end

endmodule

// File: tb/tb_apb_delayer_scaled.sv
// tb/tb_apb_delayer_scaled.sv - directed bench for apb_delayer_scaled across three ratio/width configurations.
module tb_apb_delayer_scaled;

    localparam logic [31:0] JUNK = 32'h0BAD0BAD;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_bypass [3];
    logic [31:0] in_paddr   [3];
    logic        in_psel    [3];
    logic        in_penable [3];
    logic [2:0]  in_pprot   [3];
    logic        in_pwrite  [3];
    logic [31:0] in_pwdata  [3];
    logic [3:0]  in_pstrb   [3];
    logic        in_pready  [3];
    logic [31:0] in_prdata  [3];
    logic        in_pslverr [3];
    logic [31:0] out_paddr  [3];
    logic        out_psel   [3];
    logic        out_penable[3];
    logic [2:0]  out_pprot  [3];
    logic        out_pwrite [3];
    logic [31:0] out_pwdata [3];
    logic [3:0]  out_pstrb  [3];
    logic        out_pready [3];
    logic [31:0] out_prdata [3];
    logic        out_pslverr[3];
    logic        stat_abort [3];

    int n_vec = 0;
    int n_err = 0;
    bit exp_abort [3];

    always #5 clock = ~clock;

    // 0: NUM=2 SHIFT=0 CNT_W=16, 1: NUM=3 SHIFT=1 CNT_W=16, 2: NUM=2 SHIFT=0 CNT_W=4
    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_delayer_scaled #(
            .ADDR_W(32), .DATA_W(32),
            .CNT_W(g == 2 ? 4 : 16),
            .RATIO_NUM(g == 1 ? 3 : 2),
            .RATIO_SHIFT(g == 1 ? 1 : 0)
        ) u_dut (
            .clock(clock), .reset(reset), .cfg_bypass(cfg_bypass[g]),
            .in_paddr(in_paddr[g]), .in_psel(in_psel[g]), .in_penable(in_penable[g]),
            .in_pprot(in_pprot[g]), .in_pwrite(in_pwrite[g]), .in_pwdata(in_pwdata[g]),
            .in_pstrb(in_pstrb[g]), .in_pready(in_pready[g]), .in_prdata(in_prdata[g]),
            .in_pslverr(in_pslverr[g]), .out_paddr(out_paddr[g]), .out_psel(out_psel[g]),
            .out_penable(out_penable[g]), .out_pprot(out_pprot[g]), .out_pwrite(out_pwrite[g]),
            .out_pwdata(out_pwdata[g]), .out_pstrb(out_pstrb[g]), .out_pready(out_pready[g]),
            .out_prdata(out_prdata[g]), .out_pslverr(out_pslverr[g]), .stat_abort(stat_abort[g])
        );
    end

    function automatic int tgt(input int kd, input int num, input int shf, input int maxv);
        int s;
        s = (kd * num) >>> shf;
        if (s > maxv) s = maxv;
        return (s > kd) ? s : kd;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_cyc(input int idx, input logic ep, input logic en, input logic er);
        chk1("out_psel", out_psel[idx], ep);
        chk1("out_penable", out_penable[idx], en);
        chk1("in_pready", in_pready[idx], er);
        chk1("stat_abort", stat_abort[idx], exp_abort[idx]);
        chk1("pwrite_copy", out_pwrite[idx], in_pwrite[idx]);
        chkw("paddr_copy", out_paddr[idx], in_paddr[idx]);
        chkw("pwdata_copy", out_pwdata[idx], in_pwdata[idx]);
        chkw("ctl_copy", {25'b0, out_pprot[idx], out_pstrb[idx]}, {25'b0, in_pprot[idx], in_pstrb[idx]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 3; j++) begin
                in_psel[j]    = 1'b0;
                in_penable[j] = 1'b0;
            end
            #4;
            for (int j = 0; j < 3; j++) chk_cyc(j, 1'b0, 1'b0, 1'b0);
            @(posedge clock); #1;
        end
    endtask

    // One upstream transfer; the slave answers after wait_n wait states.
    // brk_at: access cycle where psel is dropped (brk_rst=0) or reset asserted (brk_rst=1).
    task automatic xfer(input int idx, input bit byp, input bit wr, input logic [31:0] rd,
                        input bit err, input int wait_n, input int brk_at, input bit brk_rst,
                        output int got_len);
        int maxv, ready_c, kd, tg, exp_len;
        bit done;
        maxv    = (idx == 2) ? 15 : 65535;
        ready_c = wait_n + 1;
        kd      = (ready_c > maxv) ? maxv : ready_c;
        tg      = tgt(kd, (idx == 1) ? 3 : 2, (idx == 1) ? 1 : 0, maxv);
        exp_len = byp ? ready_c : ready_c + (tg - kd) + 1;
        got_len = 0;
        in_psel[idx]     = 1'b1;
        in_penable[idx]  = 1'b0;
        in_pwrite[idx]   = wr;
        in_paddr[idx]    = $urandom;
        in_pwdata[idx]   = $urandom;
        in_pprot[idx]    = 3'($urandom);
        in_pstrb[idx]    = 4'($urandom);
        cfg_bypass[idx]  = byp;
        out_pready[idx]  = 1'b0;
        out_prdata[idx]  = JUNK;
        out_pslverr[idx] = 1'b0;
        #4;
        chk_cyc(idx, 1'b1, 1'b0, 1'b0);
        @(posedge clock); #1;
        done = 1'b0;
        for (int c = 1; c <= exp_len && !done; c++) begin
            in_penable[idx] = 1'b1;
            if (byp && c == 1) cfg_bypass[idx] = 1'b0;
            out_pready[idx]  = (c == ready_c) || (!byp && c > ready_c);
            out_prdata[idx]  = (c == ready_c) ? rd : JUNK;
            out_pslverr[idx] = (c == ready_c) ? err : !err;
            if (c == brk_at) begin
                done = 1'b1;
                if (brk_rst) begin
                    reset = 1'b1;
                end else begin
                    in_psel[idx]    = 1'b0;
                    in_penable[idx] = 1'b0;
                end
            end
            #4;
            chk_cyc(idx, in_psel[idx] && (c <= ready_c), in_penable[idx] && (c <= ready_c),
                    c == exp_len);
            if (in_pready[idx] === 1'b1 && got_len == 0) got_len = c;
            if (c == exp_len) begin
                chkw("resp_prdata", in_prdata[idx], rd);
                chk1("resp_pslverr", in_pslverr[idx], err);
            end
            @(posedge clock); #1;
            if (done) begin
                if (brk_rst) exp_abort = '{default: 1'b0};
                else         exp_abort[idx] = 1'b1;
            end
        end
        in_psel[idx]    = 1'b0;
        in_penable[idx] = 1'b0;
        out_pready[idx] = 1'b0;
        cfg_bypass[idx] = 1'b0;
    endtask

    initial begin
        int g;
        reset = 1'b1;
        exp_abort = '{default: 1'b0};
        for (int j = 0; j < 3; j++) begin
            cfg_bypass[j] = 1'b0; in_paddr[j] = '0; in_psel[j] = 1'b0; in_penable[j] = 1'b0;
            in_pprot[j] = '0; in_pwrite[j] = 1'b0; in_pwdata[j] = '0; in_pstrb[j] = '0;
            out_pready[j] = 1'b0; out_prdata[j] = '0; out_pslverr[j] = 1'b0;
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        #4;
        for (int j = 0; j < 3; j++) begin
            chk_cyc(j, 1'b0, 1'b0, 1'b0);
            chkw("rst_prdata", in_prdata[j], 32'h0);
            chk1("rst_pslverr", in_pslverr[j], 1'b0);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        idle(1);

        // zero-wait read, ratio 2
        xfer(0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 0, g);
        chkw("t1_len", g, 3);
        // three wait states, then back-to-back transfer
        xfer(0, 0, 0, 32'h12345678, 0, 3, 0, 0, g);
        chkw("t2_len", g, 9);
        xfer(0, 0, 1, 32'h00005A5A, 0, 1, 0, 0, g);
        chkw("t2b_len", g, 5);
        idle(1);

        chkw("model_t3", tgt(5, 3, 1, 65535), 7);
        chkw("model_t5", tgt(15, 2, 0, 15), 15);

        // ratio 3/2, erroring write
        xfer(1, 0, 1, 32'h0, 1, 4, 0, 0, g);
        chkw("t3_len", g, 8);
        idle(1);

        // bypass with mid-access cfg toggle, then a scaled transfer
        xfer(0, 1, 0, 32'hB00B1E55, 1, 2, 0, 0, g);
        chkw("t4_len_bypass", g, 3);
        xfer(0, 0, 0, 32'h00000007, 0, 0, 0, 0, g);
        chkw("t4_len_scaled", g, 3);
        idle(1);

        // 4-bit counter saturation, then abort in WAIT
        xfer(2, 0, 0, 32'hA5A5A5A5, 0, 20, 0, 0, g);
        chkw("t5_len_sat", g, 22);
        xfer(2, 0, 0, 32'h11111111, 0, 2, 5, 0, g);
        idle(2);
        chk1("t5_abort", stat_abort[2], 1'b1);

        // abort on instance 0, then reset in WAIT clears it
        xfer(0, 0, 0, 32'h22222222, 0, 0, 2, 0, g);
        idle(1);
        chk1("t6_abort_set", stat_abort[0], 1'b1);
        xfer(0, 0, 0, 32'h33333333, 0, 3, 6, 1, g);
        in_psel[0] = 1'b1;
        #4;
        chk_cyc(0, 1'b1, 1'b0, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle(2);
        xfer(0, 0, 0, 32'h0000FEED, 0, 1, 0, 0, g);
        chkw("t6_len_after", g, 5);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
